// File: rtl/w_input_conditioner.sv
// w_input_conditioner: synchronizes and debounces a raw async input into the clean level w.
// Ports: Clock (rising edge), Resetn (async active-low), raw_in (async, may bounce),
//        w (debounced level), w_rise/w_fall (one-cycle edge pulses),
//        glitch_cnt (saturating rejected-glitch count, only when GLITCH_COUNT_EN is defined).
module w_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic raw_in,
  output logic w,
  output logic w_rise,
  output logic w_fall
`ifdef GLITCH_COUNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);
  typedef enum logic [1:0] {S_LOW = 2'b00, S_RISE = 2'b01, S_HIGH = 2'b10, S_FALL = 2'b11} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, s;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic w_n, rise_n, fall_n;
  assign s = sync2;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= S_LOW;
      cnt <= '0;
      w <= 1'b0;
      w_rise <= 1'b0;
      w_fall <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      state <= state_n;
      cnt <= cnt_n;
      w <= w_n;
      w_rise <= rise_n;
      w_fall <= fall_n;
    end
  // A reversal on the terminal-count edge is tested first, so the glitch path wins.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    w_n = w;
    rise_n = 1'b0;
    fall_n = 1'b0;
    case (state)
      S_LOW:
        if (s) begin
          state_n = S_RISE;
          cnt_n = '0;
        end
      S_RISE:
        if (!s) state_n = S_LOW;
        else if (cnt == LAST) begin
          state_n = S_HIGH;
          w_n = 1'b1;
          rise_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      S_HIGH:
        if (!s) begin
          state_n = S_FALL;
          cnt_n = '0;
        end
      S_FALL:
        if (s) state_n = S_HIGH;
        else if (cnt == LAST) begin
          state_n = S_LOW;
          w_n = 1'b0;
          fall_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
    endcase
  end
`ifdef GLITCH_COUNT_EN
  logic glitch;
  assign glitch = (state == S_RISE && !s) || (state == S_FALL && s);
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) glitch_cnt <= '0;
    else if (glitch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 1'b1;
`endif
endmodule

// File: doc/w_input_conditioner.md
Name: w_input_conditioner

Overview:
- Upstream stage of the two-consecutive-high sequence detector. Turns an asynchronous, bouncy raw input (push-button or switch) into the clean, synchronous level `w` that the detector samples.
- Processing chain: 2-flop synchronizer, then a debounce FSM with a hold counter, then registered level and edge-pulse outputs.
- Guarantees the detector never sees a metastable value or a bounce-induced pulse.

Parameters:
- DEBOUNCE_CYCLES, default 4: number of consecutive clocks the synchronized input must hold a new value before `w` follows it. Legal range is 1..65535; 0 is illegal.
- CNT_W, default 16: hold-counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clock   input   1       system clock; all flops on its rising edge.
- Resetn  input   1       asynchronous, active-low reset. Asserted means every flop clears immediately.
- raw_in  input   1       asynchronous raw input; may bounce.
- w       output  1       debounced, registered level; feeds the detector's `w`.
- w_rise  output  1       one-cycle pulse, registered, on each 0->1 transition of `w`.
- w_fall  output  1       one-cycle pulse, registered, on each 1->0 transition of `w`.
- glitch_cnt  output  8   rejected-glitch count. Present only with GLITCH_COUNT_EN.

Behaviour:
- Interface: single clock `Clock`. Reset `Resetn` is asynchronous and active-low; on its falling edge all state clears without waiting for a clock.
- Reset values: sync1=0, sync2=0, state=S_LOW, cnt=0, w=0, w_rise=0, w_fall=0, glitch_cnt=0.
- Synchronizer: sync1<=raw_in, then sync2<=sync1. Only `s`=sync2 is used downstream of the synchronizer.
- FSM states, 2-bit encoding: S_LOW=00, S_RISE=01, S_HIGH=10, S_FALL=11.
  - S_LOW: if s=1, go to S_RISE with cnt<=0. Otherwise stay.
  - S_RISE, s=0: go to S_LOW. This is a rejected glitch.
  - S_RISE, s=1 and cnt==DEBOUNCE_CYCLES-1: go to S_HIGH. Same edge sets w<=1 and w_rise<=1.
  - S_RISE, s=1 otherwise: cnt<=cnt+1.
  - S_HIGH: if s=0, go to S_FALL with cnt<=0. Otherwise stay.
  - S_FALL: mirror of S_RISE with polarity swapped.
    - s=1: go to S_HIGH (rejected glitch).
    - s=0 and cnt==DEBOUNCE_CYCLES-1: go to S_LOW. Same edge sets w<=0 and w_fall<=1.
    - s=0 otherwise: cnt<=cnt+1.
- Outputs:
  - `w` is a dedicated flop updated on the same edge as the state transition. It is never a combinational decode, so it cannot glitch.
  - `w` is 1 in S_HIGH and S_FALL, and 0 in S_LOW and S_RISE.
  - w_rise and w_fall default to 0 every cycle. Each is high for exactly one cycle, aligned with the first cycle of the new `w` value.
- Latency: if raw_in is stable at the new value before edge k, `w` changes at edge k+DEBOUNCE_CYCLES+2. Examples: DEBOUNCE_CYCLES=4 gives edge k+6; DEBOUNCE_CYCLES=1 gives edge k+3.
- Boundary conditions:
  - Reversal on the terminal-count edge: if s reverts on the same edge where cnt==DEBOUNCE_CYCLES-1, the glitch path wins. `w` does not change.
  - Counter overflow: cnt is only incremented below DEBOUNCE_CYCLES-1, so it never wraps.
  - Reset mid-debounce (S_RISE or S_FALL): return to S_LOW with w=0, even if `w` was 1.
  - Reset release: raw_in high at release is debounced normally. `w` rises DEBOUNCE_CYCLES+2 edges after the first edge with Resetn=1.

Optional Feature:
- Macro GLITCH_COUNT_EN.
- Defined:
  - Port glitch_cnt[7:0] exists.
  - It increments by 1 on each S_RISE->S_LOW or S_FALL->S_HIGH transition.
  - It saturates at 255 and clears only on reset.
- Undefined:
  - glitch_cnt port and its logic are absent.
  - All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold Resetn=0 with raw_in=1 -> w=0, w_rise=0, w_fall=0 throughout. Assert Resetn=0 asynchronously mid-cycle while w=1 -> w=0 before the next Clock edge.
- Clean press: raw_in 0->1 before edge 10, then held -> w=1 from edge 16; w_rise=1 for exactly the cycle after edge 16; w_fall stays 0.
- Bounce rejected: raw_in high for 3 cycles, then low -> w stays 0, no pulses. Under GLITCH_COUNT_EN, glitch_cnt=1.
- Clean release: with w=1, raw_in 1->0 before edge 40, then held -> w=0 from edge 46; w_fall pulses one cycle.
- Terminal-edge reversal: raw_in high exactly long enough for s to be 1 for 4 edges, dropping on the 5th -> w stays 0, and it is counted as a glitch.
- Saturation (GLITCH_COUNT_EN only): 300 two-cycle pulses on raw_in -> glitch_cnt=255 and stays at 255; w never rises.
